// File: rtl/mbc_sync_mapper.sv
// mbc_sync_mapper: clocked MBC1/MBC5 bank mapper for a Game Boy cartridge.
// The GB bus is resynchronised into clk, the write strobe is glitch-filtered,
// and bank-register writes are committed by a small FSM.
// Optional macro MBC_RUMBLE_EN: adds a rumble output driven by ram_reg[3]
// (MBC5 only) and forces ram_bank[3] to 0.
//
// state  | meaning
// IDLE   | waiting for synced write strobe to go low
// LOW    | strobe low, counting low cycles and latching addr/data
// COMMIT | strobe released after a long enough low, update register
module mbc_sync_mapper #(
  parameter int MBC_TYPE   = 0,
  parameter int ROM_BANK_W = 9,
  parameter int RAM_BANK_W = 4,
  parameter int FILTER     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  gb_write_n,
  input  logic                  gb_read_n,
  input  logic                  cs_n,
  input  logic [3:0]            gb_addr_hi,
  input  logic [7:0]            gb_data,
  output logic [ROM_BANK_W-1:0] rom_bank,
  output logic [RAM_BANK_W-1:0] ram_bank,
  output logic                  ram_cs,
  output logic                  ram_cs_n,
  output logic                  rom_cs_n,
  output logic                  wr_commit
`ifdef MBC_RUMBLE_EN
  ,
  output logic                  rumble
`endif
);

  typedef enum logic [1:0] {IDLE, LOW, COMMIT} state_t;

  localparam logic [3:0] FILT = FILTER[3:0];

  state_t      state, state_nxt;
  logic [1:0]  wr_sync;
  logic [3:0]  addr_s1, addr_s2, lat_addr;
  logic [7:0]  data_s1, data_s2, lat_data;
  logic [3:0]  cnt;
  logic        write_n_s;
  logic        ram_en, mode;
  logic [8:0]  rom_reg;
  logic [3:0]  ram_reg;
  logic [8:0]  rom_full;
  logic [3:0]  ram_full;
  logic [4:0]  rom_lo_eff;
  logic        unused_ok;

  assign write_n_s = wr_sync[1];

  // Two-flop synchronisers; strobe idles high so reset cannot fake a write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sync <= 2'b11;
      addr_s1 <= '0;
      addr_s2 <= '0;
      data_s1 <= '0;
      data_s2 <= '0;
    end else begin
      wr_sync <= {wr_sync[0], gb_write_n};
      addr_s1 <= gb_addr_hi;
      addr_s2 <= addr_s1;
      data_s1 <= gb_data;
      data_s2 <= data_s1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: a short low pulse falls back to IDLE without a commit
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!write_n_s) state_nxt = LOW;
      LOW:     if (write_n_s) state_nxt = (cnt >= FILT) ? COMMIT : IDLE;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Low-time counter (saturating) and address/data latch while strobe is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      lat_addr <= '0;
      lat_data <= '0;
    end else if (!write_n_s && (state == IDLE || state == LOW)) begin
      if (state == IDLE)       cnt <= 4'd1;
      else if (cnt != 4'hF)    cnt <= cnt + 4'd1;
      lat_addr <= addr_s2;
      lat_data <= data_s2;
    end
  end

  // Bank registers updated from the latched write; commit pulse aligned with the update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en    <= 1'b0;
      rom_reg   <= 9'd1;
      ram_reg   <= '0;
      mode      <= 1'b0;
      wr_commit <= 1'b0;
    end else begin
      wr_commit <= (state == COMMIT);
      if (state == COMMIT) begin
        if (MBC_TYPE == 1) begin
          case (lat_addr)
            4'b0000, 4'b0001: ram_en <= (lat_data[3:0] == 4'hA);
            4'b0010:          rom_reg[7:0] <= lat_data;
            4'b0011:          if (ROM_BANK_W >= 9) rom_reg[8] <= lat_data[0];
            4'b0100, 4'b0101: ram_reg <= lat_data[3:0];
            default: ;
          endcase
        end else begin
          case (lat_addr[3:1])
            3'b000: ram_en <= (lat_data[3:0] == 4'hA);
            3'b001: rom_reg <= {4'b0, lat_data[4:0]};
            3'b010: ram_reg <= {2'b0, lat_data[1:0]};
            3'b011: mode <= lat_data[0];
            default: ;
          endcase
        end
      end
    end
  end

  assign rom_lo_eff = (rom_reg[4:0] == 5'd0) ? 5'd1 : rom_reg[4:0];

  // Bank outputs from registers and raw A14 so the ROM address follows the bus directly
  always_comb begin
    rom_full = '0;
    ram_full = '0;
    if (MBC_TYPE == 1) begin
      if (gb_addr_hi[2]) rom_full = rom_reg;
      ram_full = ram_reg;
`ifdef MBC_RUMBLE_EN
      ram_full[3] = 1'b0;
`endif
    end else begin
      if (gb_addr_hi[2])  rom_full = {2'b0, ram_reg[1:0], rom_lo_eff};
      else if (mode)      rom_full = {2'b0, ram_reg[1:0], 5'b0};
      if (mode)           ram_full = {2'b0, ram_reg[1:0]};
    end
  end

  assign rom_bank = ROM_BANK_W'(rom_full);
  assign ram_bank = RAM_BANK_W'(ram_full);

`ifdef MBC_RUMBLE_EN
  assign rumble = (MBC_TYPE == 1) ? ram_reg[3] : 1'b0;
`endif

  // Chip selects decoded from the raw bus
  assign ram_cs   = ~cs_n & (gb_addr_hi[3:1] == 3'b101) & ram_en;
  assign ram_cs_n = ~ram_cs;
  assign rom_cs_n = ~(~gb_addr_hi[3] & ~gb_read_n & rst_n);

  assign unused_ok = &{1'b0, gb_addr_hi[0], lat_addr[0], lat_data[7:5], rom_reg};

endmodule

// File: tb/tb_mbc_sync_mapper.sv
module tb_mbc_sync_mapper;

  localparam int FILT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       gb_write_n = 1'b1;
  logic       gb_read_n = 1'b1;
  logic       cs_n = 1'b1;
  logic [3:0] gb_addr_hi = 4'h4;
  logic [7:0] gb_data = 8'h00;

  logic [8:0] rb1, rb5;
  logic [3:0] qb1, qb5;
  logic       rcs1, rcsn1, romcsn1, wc1;
  logic       rcs5, rcsn5, romcsn5, wc5;
`ifdef MBC_RUMBLE_EN
  logic       rum1, rum5;
`endif

  int n_chk = 0;
  int n_fail = 0;
  bit exp_commit = 1'b0;

  // behavioural model state
  bit       m1_en, m1_mode;
  bit [4:0] m1_lo;
  bit [1:0] m1_ram;
  bit       m5_en;
  bit [8:0] m5_rom;
  bit [3:0] m5_ram;

  always #5 clk = ~clk;

  mbc_sync_mapper #(.MBC_TYPE(0), .ROM_BANK_W(9), .RAM_BANK_W(4), .FILTER(FILT)) u1 (
    .clk(clk), .rst_n(rst_n), .gb_write_n(gb_write_n), .gb_read_n(gb_read_n),
    .cs_n(cs_n), .gb_addr_hi(gb_addr_hi), .gb_data(gb_data),
    .rom_bank(rb1), .ram_bank(qb1), .ram_cs(rcs1), .ram_cs_n(rcsn1),
    .rom_cs_n(romcsn1), .wr_commit(wc1)
`ifdef MBC_RUMBLE_EN
    , .rumble(rum1)
`endif
  );

  mbc_sync_mapper #(.MBC_TYPE(1), .ROM_BANK_W(9), .RAM_BANK_W(4), .FILTER(FILT)) u5 (
    .clk(clk), .rst_n(rst_n), .gb_write_n(gb_write_n), .gb_read_n(gb_read_n),
    .cs_n(cs_n), .gb_addr_hi(gb_addr_hi), .gb_data(gb_data),
    .rom_bank(rb5), .ram_bank(qb5), .ram_cs(rcs5), .ram_cs_n(rcsn5),
    .rom_cs_n(romcsn5), .wr_commit(wc5)
`ifdef MBC_RUMBLE_EN
    , .rumble(rum5)
`endif
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m1_en = 0; m1_mode = 0; m1_lo = 5'd1; m1_ram = 0;
    m5_en = 0; m5_rom = 9'd1; m5_ram = 0;
    exp_commit = 0;
  endtask

  task automatic model_write(input logic [3:0] a, input logic [7:0] d);
    int top;
    top = a >> 1;
    if (top == 0) m1_en = (d % 16 == 10);
    else if (top == 1) m1_lo = d % 32;
    else if (top == 2) m1_ram = d % 4;
    else if (top == 3) m1_mode = d % 2;
    if (a <= 1) m5_en = (d % 16 == 10);
    else if (a == 2) m5_rom = (m5_rom / 256) * 256 + d;
    else if (a == 3) m5_rom = (d % 2) * 256 + m5_rom % 256;
    else if (a == 4 || a == 5) m5_ram = d % 16;
  endtask

  function automatic logic [8:0] exp_rom1();
    int lo;
    lo = (m1_lo == 0) ? 1 : m1_lo;
    if (gb_addr_hi[2]) return 9'(m1_ram * 32 + lo);
    return m1_mode ? 9'(m1_ram * 32) : 9'd0;
  endfunction

  function automatic logic [3:0] exp_ram1();
    return m1_mode ? {2'b0, m1_ram} : 4'd0;
  endfunction

  function automatic logic [8:0] exp_rom5();
    return gb_addr_hi[2] ? m5_rom : 9'd0;
  endfunction

  function automatic logic [3:0] exp_ram5();
`ifdef MBC_RUMBLE_EN
    return m5_ram % 8;
`else
    return m5_ram;
`endif
  endfunction

  function automatic logic exp_cs(input bit en);
    return (cs_n == 1'b0) && (gb_addr_hi[3:1] == 3'b101) && en;
  endfunction

  function automatic logic exp_romcs_n();
    return !((gb_addr_hi[3] == 1'b0) && (gb_read_n == 1'b0) && (rst_n == 1'b1));
  endfunction

  // Compare process: every falling edge, both DUTs against the model
  always @(negedge clk) begin
    chk("rom_bank_mbc1", 16'(rb1), 16'(exp_rom1()));
    chk("ram_bank_mbc1", 16'(qb1), 16'(exp_ram1()));
    chk("rom_bank_mbc5", 16'(rb5), 16'(exp_rom5()));
    chk("ram_bank_mbc5", 16'(qb5), 16'(exp_ram5()));
    chk("ram_cs_mbc1", 16'(rcs1), 16'(exp_cs(m1_en)));
    chk("ram_cs_n_mbc1", 16'(rcsn1), 16'(!exp_cs(m1_en)));
    chk("ram_cs_mbc5", 16'(rcs5), 16'(exp_cs(m5_en)));
    chk("ram_cs_n_mbc5", 16'(rcsn5), 16'(!exp_cs(m5_en)));
    chk("rom_cs_n_mbc1", 16'(romcsn1), 16'(exp_romcs_n()));
    chk("rom_cs_n_mbc5", 16'(romcsn5), 16'(exp_romcs_n()));
    chk("wr_commit_mbc1", 16'(wc1), 16'(exp_commit));
    chk("wr_commit_mbc5", 16'(wc5), 16'(exp_commit));
`ifdef MBC_RUMBLE_EN
    chk("rumble_mbc1", 16'(rum1), 16'd0);
    chk("rumble_mbc5", 16'(rum5), 16'(m5_ram / 8));
`endif
  end

  // Write cycle with n clk of strobe low; commit expected on the 4th edge after release
  task automatic wr(input logic [3:0] a, input logic [7:0] d, input int n);
    bit ok;
    ok = (n >= FILT);
    @(posedge clk); #2;
    gb_addr_hi = a; gb_data = d; gb_write_n = 1'b0;
    repeat (n) @(posedge clk);
    #2 gb_write_n = 1'b1;
    repeat (3) @(posedge clk);
    #3 chk("commit_early_mbc1", 16'(wc1), 16'd0);
    @(posedge clk);
    #1 if (ok) begin model_write(a, d); exp_commit = 1'b1; end
    #2 chk("commit_edge_mbc1", 16'(wc1), 16'(ok));
    chk("commit_edge_mbc5", 16'(wc5), 16'(ok));
    @(posedge clk);
    #1 exp_commit = 1'b0;
  endtask

  task automatic set_bus(input logic [3:0] a, input logic c, input logic r);
    @(posedge clk); #2;
    gb_addr_hi = a; cs_n = c; gb_read_n = r;
    #1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    set_bus(4'h4, 1'b1, 1'b1);
    chk("reset_rom_mbc1", 16'(rb1), 16'h1);
    chk("reset_rom_mbc5", 16'(rb5), 16'h1);

    // reset in the middle of a long low strobe
    @(posedge clk); #2;
    gb_addr_hi = 4'h2; gb_data = 8'h05; gb_write_n = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0; model_reset(); gb_write_n = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    set_bus(4'h4, 1'b1, 1'b1);
    chk("abort_rom_mbc1", 16'(rb1), 16'h1);
    chk("abort_ram_mbc1", 16'(qb1), 16'h0);
    chk("abort_rom_mbc5", 16'(rb5), 16'h1);

    // MBC1 zero remap and mode 1
    wr(4'h2, 8'h00, 3);
    wr(4'h4, 8'h02, 3);
    set_bus(4'h4, 1'b1, 1'b1);
    chk("mbc1_remap", 16'(rb1), 16'h41);
    chk("mbc1_mode0_ram", 16'(qb1), 16'h0);
    wr(4'h6, 8'h01, 3);
    set_bus(4'h0, 1'b1, 1'b1);
    chk("mbc1_mode1_rom", 16'(rb1), 16'h40);
    chk("mbc1_mode1_ram", 16'(qb1), 16'h2);

    // MBC5 9-bit bank, no zero remap
    wr(4'h2, 8'hFF, 3);
    wr(4'h3, 8'h01, 3);
    set_bus(4'h4, 1'b1, 1'b1);
    chk("mbc5_rom_1ff", 16'(rb5), 16'h1FF);
    wr(4'h2, 8'h00, 3);
    set_bus(4'h4, 1'b1, 1'b1);
    chk("mbc5_rom_100", 16'(rb5), 16'h100);

    // RAM enable and chip select, enable write exactly FILTER cycles long
    wr(4'h0, 8'h0A, FILT);
    set_bus(4'hA, 1'b0, 1'b1);
    chk("ram_cs_on_mbc1", 16'(rcs1), 16'h1);
    chk("ram_cs_n_on_mbc1", 16'(rcsn1), 16'h0);
    chk("ram_cs_on_mbc5", 16'(rcs5), 16'h1);
    set_bus(4'hC, 1'b0, 1'b1);
    chk("ram_cs_wrong_area", 16'(rcs1), 16'h0);
    wr(4'h0, 8'h0B, 3);
    set_bus(4'hA, 1'b0, 1'b1);
    chk("ram_cs_off_mbc1", 16'(rcs1), 16'h0);
    set_bus(4'h4, 1'b1, 1'b1);

    // glitch filter
    wr(4'h2, 8'h07, 1);
    set_bus(4'h4, 1'b1, 1'b1);
    chk("glitch_rom_mbc1", 16'(rb1), 16'h41);
    chk("glitch_rom_mbc5", 16'(rb5), 16'h100);
    wr(4'h2, 8'h07, 3);
    set_bus(4'h4, 1'b1, 1'b1);
    chk("accept_rom_mbc1", 16'(rb1), 16'h47);
    chk("accept_rom_mbc5", 16'(rb5), 16'h107);

    // A15=1 writes leave registers alone
    wr(4'hA, 8'h00, 3);
    set_bus(4'h4, 1'b1, 1'b1);
    chk("a15_write_mbc1", 16'(rb1), 16'h47);

    // ROM chip select follows read strobe and A15
    set_bus(4'h4, 1'b1, 1'b0);
    chk("rom_cs_n_read", 16'(romcsn1), 16'h0);
    set_bus(4'h8, 1'b1, 1'b0);
    chk("rom_cs_n_a15", 16'(romcsn1), 16'h1);
    set_bus(4'h4, 1'b1, 1'b1);

`ifdef MBC_RUMBLE_EN
    wr(4'h4, 8'h0F, 3);
    set_bus(4'h4, 1'b1, 1'b1);
    chk("rumble_on", 16'(rum5), 16'h1);
    chk("rumble_ram_bank", 16'(qb5), 16'h7);
    wr(4'h4, 8'h03, 3);
    set_bus(4'h4, 1'b1, 1'b1);
    chk("rumble_off", 16'(rum5), 16'h0);
    chk("rumble_ram_bank3", 16'(qb5), 16'h3);
`else
    wr(4'h4, 8'h0F, 3);
    set_bus(4'h4, 1'b1, 1'b1);
    chk("mbc5_ram_bank_f", 16'(qb5), 16'hF);
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mbc_sync_mapper.md
Name: mbc_sync_mapper

Overview:
- Clocked, parametrised successor to the asynchronous MBC1 mapper; supports MBC1 and MBC5 banking selected by parameter.
- Samples the Game Boy cartridge bus (write strobe, upper address, data) into the board clock domain and glitch-filters the write strobe.
- Commits bank-register writes with a small FSM.
- Drives upper ROM/RAM address lines and chip selects between the cartridge edge connector and the ROM/SRAM chips.

Parameters:
- MBC_TYPE, 0, 0 = MBC1 banking, 1 = MBC5 banking.
- ROM_BANK_W, 9, width of rom_bank output; MBC1 uses the low 7 bits, upper bits driven 0.
- RAM_BANK_W, 4, width of ram_bank output; MBC1 uses the low 2 bits, upper bits driven 0.
- FILTER, 2, minimum consecutive synced-low clk cycles of gb_write_n for a write to be accepted (1..15).

Ports:
- clk  in  1  board clock, at least 8x the GB bus rate.
- rst_n  in  1  asynchronous, active-low reset.
- gb_write_n  in  1  GB write strobe, asynchronous to clk.
- gb_read_n  in  1  GB read strobe.
- cs_n  in  1  GB cartridge RAM-area chip select.
- gb_addr_hi  in  4  GB A15..A12.
- gb_data  in  8  GB D7..D0.
- rom_bank  out  ROM_BANK_W  ROM bank for the current access (drives ROM A14 and up).
- ram_bank  out  RAM_BANK_W  SRAM bank (drives SRAM A13 and up).
- ram_cs  out  1  SRAM chip select, active high.
- ram_cs_n  out  1  inverse of ram_cs.
- rom_cs_n  out  1  ROM chip select, active low.
- wr_commit  out  1  one-cycle pulse when a register write is committed.

Behaviour:
- Reset (async, rst_n=0): ram_en=0, rom_reg=1, ram_reg=0, mode=0, FSM=IDLE, synchronisers cleared to idle (write_n=1). rom_bank therefore reads 1 for A14=1 and 0 for A14=0; ram_bank=0; wr_commit=0. Reset mid-write aborts the write, and no register changes.
- Synchronisers: gb_write_n, gb_addr_hi and gb_data each pass through 2 flops; the FSM uses the synced values only.
- FSM states:
  - IDLE: go to LOW when synced write_n=0; cnt=1.
  - LOW: while write_n=0, cnt++ (saturating) and latch addr/data every cycle. If write_n=1 and cnt<FILTER, return to IDLE with nothing committed. If write_n=1 and cnt>=FILTER, go to COMMIT.
  - COMMIT: update the decoded register from the latched addr/data, pulse wr_commit=1 for exactly 1 cycle, then go to IDLE.
- Latency: the register value and its outputs are valid on the 4th clk edge after gb_write_n rises (2 sync + LOW exit + COMMIT).
- Write decode in MBC1 mode (latched A15..A13):
  - 000: ram_en = (D[3:0]==4'hA).
  - 001: rom_lo = D[4:0]; a stored 0 reads as 1.
  - 010: ram_reg = D[1:0].
  - 011: mode = D[0].
- Write decode in MBC5 mode (latched A15..A12):
  - 000x: ram_en = (D[3:0]==4'hA).
  - 0010: rom_reg[7:0] = D.
  - 0011: rom_reg[8] = D[0], ignored if ROM_BANK_W<9.
  - 010x: ram_reg = D[3:0].
  - 011x: ignored. Zero is not remapped (bank 0 in the 4000-7FFF window is legal).
- Writes with A15=1 never touch registers.
- Outputs are combinational from the registers and raw gb_addr_hi[2] (A14).
  - MBC1: A14=1 gives rom_bank = {ram_reg, rom_lo (0→1)}. A14=0 gives mode ? {ram_reg,5'b0} : 0. ram_bank = mode ? ram_reg : 0.
  - MBC5: A14=1 gives rom_bank = rom_reg. A14=0 gives 0. ram_bank = ram_reg.
  - Bank values are truncated or zero-extended to the port widths.
- Chip selects:
  - ram_cs = ~cs_n & (raw A15..A13==3'b101) & ram_en.
  - rom_cs_n = ~(~A15 & ~gb_read_n & rst_n).
- Back-to-back writes: a new falling edge seen during COMMIT is handled from IDLE on the next cycle, so no write is lost if the low time is >= FILTER+1 cycles.

Optional Feature:
- Macro: MBC_RUMBLE_EN.
- Defined, with MBC_TYPE=1: adds output port rumble (1 bit, reset 0), driven by ram_reg[3]. ram_bank[3] is forced 0 and rumble carts address 8 SRAM banks.
- Defined, with MBC_TYPE=0: rumble is tied to 0.
- Not defined: no rumble port exists, and ram_bank[3] follows ram_reg[3].

Test Plan:
- Reset: assert rst_n=0 mid-LOW with A15..A13=001, D=0x05 -> after release rom_bank=1 (A14=1), ram_bank=0, wr_commit never pulsed.
- MBC1 zero remap: write 0x00 to 0x2000, 0x02 to 0x4000, A14=1 -> rom_bank=0x41. Then write 0x01 to 0x6000, A14=0 -> rom_bank=0x40 and ram_bank=2.
- MBC5 9-bit bank: write 0xFF to 0x2000, 0x01 to 0x3000 -> rom_bank=0x1FF. Write 0x00 to 0x2000 -> rom_bank=0x100 (no remap).
- RAM enable/CS: write 0x0A to 0x0000, then cs_n=0 with A15..A13=101 -> ram_cs=1 and ram_cs_n=0. Write 0x0B to 0x0000 -> ram_cs=0.
- Glitch filter (FILTER=2): a 1-clk low pulse on gb_write_n with D=0x07 at 0x2000 -> no wr_commit, rom_bank unchanged. A 3-clk pulse -> wr_commit pulses once, on the 4th edge after the rising edge.
- MBC_RUMBLE_EN, MBC5: write 0x0F to 0x4000 -> rumble=1, ram_bank=0x7. Write 0x03 -> rumble=0, ram_bank=0x3.
